// File: rtl/dbus_pkg.sv
// Shared definitions for the data bus arbiter: FSM state encoding and default parameters.
package dbus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TURN  = 2'd1,
      GRANT = 2'd2
   } state_t;

   localparam int N_REQ_DEF      = 4;
   localparam int MAX_HOLD_DEF   = 8;
   localparam int TURNAROUND_DEF = 1;

endpackage

// File: rtl/data_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping N_REQ-1 -> 0.
module rr_pick #(
   parameter  int N_REQ = 4,
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic             valid,
   output logic [IDW-1:0]   idx
);

   localparam logic [IDW:0] N_W = (IDW + 1)'(N_REQ);

   function automatic logic [IDW-1:0] wrap_pos(input logic [IDW-1:0] base, input int off);
      logic [IDW:0] v_sum;
      logic [IDW:0] v_dif;
      v_sum = {1'b0, base} + (IDW + 1)'(off);
      v_dif = v_sum - N_W;
      return (v_sum >= N_W) ? v_dif[IDW-1:0] : v_sum[IDW-1:0];
   endfunction

   // Scan from the farthest offset down so the nearest request to ptr is the one kept.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[wrap_pos(ptr, i)]) begin
            valid = 1'b1;
            idx   = wrap_pos(ptr, i);
         end
      end
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin owner of the shared tri-state data bus / RAM port with turnaround dead
// cycles between owners and a lock-overridable tenure limit.
module data_bus_arbiter
   import dbus_pkg::*;
#(
   parameter  int N_REQ      = N_REQ_DEF,
   parameter  int MAX_HOLD   = MAX_HOLD_DEF,
   parameter  int TURNAROUND = TURNAROUND_DEF,
   localparam int IDW        = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] lock,
   input  logic [N_REQ-1:0] last,
   output logic [N_REQ-1:0] gnt,
   output logic [IDW-1:0]   owner_id,
   output logic             busy,
   output logic             timeout
);

   localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int TCW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

   localparam logic [HCW-1:0]   HOLD_SAT  = HCW'(MAX_HOLD);
   localparam logic [HCW-1:0]   HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [TCW-1:0]   TURN_LAST = TCW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
   localparam logic [IDW-1:0]   ID_MAX    = IDW'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);
   localparam state_t           ENTER     = (TURNAROUND == 0) ? GRANT : TURN;

   state_t           r_state, w_state_nxt;
   logic [IDW-1:0]   r_owner, w_owner_nxt;
   logic [IDW-1:0]   r_ptr, w_ptr_nxt;
   logic [TCW-1:0]   r_turn_cnt, w_turn_nxt;
   logic [HCW-1:0]   r_hold_cnt, w_hold_nxt;
   logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
   logic             r_busy;
   logic             r_timeout, w_timeout_nxt;

   logic [N_REQ-1:0] w_own_bit, w_others, w_pick_req;
   logic [IDW-1:0]   w_own_next, w_pick_ptr, w_pick_idx;
   logic             w_pick_valid, w_req_own, w_lock_own, w_last_own, w_force;

   assign w_own_bit  = ONE << r_owner;
   assign w_own_next = (r_owner == ID_MAX) ? '0 : r_owner + IDW'(1);
   assign w_req_own  = |(req & w_own_bit);
   assign w_lock_own = |(lock & w_own_bit);
   assign w_last_own = |(last & w_own_bit);
   assign w_others   = req & ~w_own_bit;

   // At release the outgoing owner is excluded and the search starts just past it.
   assign w_pick_req = (r_state == GRANT) ? w_others : req;
   assign w_pick_ptr = (r_state == GRANT) ? w_own_next : r_ptr;

   // A saturated count still counts as expired, so contention arriving late forces release.
   assign w_force = (MAX_HOLD != 0) && (r_hold_cnt >= HOLD_LAST) && !w_lock_own && (|w_others);

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (w_pick_req),
      .ptr   (w_pick_ptr),
      .valid (w_pick_valid),
      .idx   (w_pick_idx)
   );

   // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_ptr_nxt     = r_ptr;
      w_turn_nxt    = r_turn_cnt;
      w_hold_nxt    = r_hold_cnt;
      w_timeout_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_owner_nxt = w_pick_idx;
               w_turn_nxt  = '0;
               w_hold_nxt  = '0;
               w_state_nxt = ENTER;
            end
         end
         TURN: begin
            if (!w_req_own) begin
               w_state_nxt = IDLE;
               w_turn_nxt  = '0;
            end else if (r_turn_cnt == TURN_LAST) begin
               w_state_nxt = GRANT;
               w_hold_nxt  = '0;
            end else begin
               w_turn_nxt = r_turn_cnt + TCW'(1);
            end
         end
         GRANT: begin
            if (!w_req_own || w_last_own || w_force) begin
               w_timeout_nxt = w_force && w_req_own && !w_last_own;
               w_ptr_nxt     = w_own_next;
               w_hold_nxt    = '0;
               w_turn_nxt    = '0;
               if (w_pick_valid) begin
                  w_owner_nxt = w_pick_idx;
                  w_state_nxt = ENTER;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (r_hold_cnt != HOLD_SAT) begin
               w_hold_nxt = r_hold_cnt + HCW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_gnt_nxt = (w_state_nxt == GRANT) ? (ONE << w_owner_nxt) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_owner    <= '0;
         r_ptr      <= '0;
         r_turn_cnt <= '0;
         r_hold_cnt <= '0;
         r_gnt      <= '0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_ptr      <= w_ptr_nxt;
         r_turn_cnt <= w_turn_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_gnt      <= w_gnt_nxt;
         r_busy     <= (w_state_nxt != IDLE);
         r_timeout  <= w_timeout_nxt;
      end
   end

   assign gnt      = r_gnt;
   assign owner_id = r_owner;
   assign busy     = r_busy;
   assign timeout  = r_timeout;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: directed scenarios plus random traffic against a tenure-level model.
module tb_data_bus_arbiter;

   localparam int N          = 4;
   localparam int MAX_HOLD   = 8;
   localparam int TURNAROUND = 1;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] req   = '0;
   logic [N-1:0] lock  = '0;
   logic [N-1:0] last  = '0;
   logic [N-1:0] gnt;
   logic [1:0]   owner_id;
   logic         busy;
   logic         timeout;

   data_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .lock     (lock),
      .last     (last),
      .gnt      (gnt),
      .owner_id (owner_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           cyc;
      logic [N-1:0] gnt;
      logic [1:0]   id;
      logic         busy;
      logic         to;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_order[5] = '{0, 1, 2, 3, 0};

   // Model: owner index, dead cycles still to wait before its grant, cycles granted so far.
   int m_id, m_ptr, m_wait, m_len;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   function automatic int idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_id = 0; m_ptr = 0; m_wait = 0; m_len = 0;
   endtask

   task automatic model_start(input int who);
      m_id = who;
      if (TURNAROUND == 0) m_len = 1;
      else m_wait = TURNAROUND;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] lk,
                             input logic [N-1:0] ls, output exp_t e);
      logic [N-1:0] others;
      bit a, b, c;
      int nxt;
      e.to = 1'b0;
      if (m_len > 0) begin
         others = r;
         others[m_id] = 1'b0;
         a = !r[m_id];
         b = ls[m_id];
         c = (MAX_HOLD != 0) && (m_len >= MAX_HOLD) && !lk[m_id] && (others != 0);
         if (a || b || c) begin
            e.to  = c && !a && !b;
            m_ptr = (m_id + 1) % N;
            m_len = 0;
            nxt   = pick(others, m_ptr);
            if (nxt >= 0) model_start(nxt);
         end else begin
            m_len++;
         end
      end else if (m_wait > 0) begin
         if (!r[m_id]) m_wait = 0;
         else begin
            m_wait--;
            if (m_wait == 0) m_len = 1;
         end
      end else begin
         nxt = pick(r, m_ptr);
         if (nxt >= 0) model_start(nxt);
      end
      e.gnt = '0;
      if (m_len > 0) e.gnt[m_id] = 1'b1;
      e.id   = 2'(m_id);
      e.busy = (m_len > 0) || (m_wait > 0);
   endtask

   // Applies one cycle of inputs, records the expected post-edge outputs, returns 1 time unit after the edge.
   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] lk, input logic [N-1:0] ls);
      exp_t e;
      req  = r;
      lock = lk;
      last = ls;
      model_step(r, lk, ls, e);
      e.cyc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit chk_async);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      if (chk_async) check("async gnt drop", gnt, 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
         mon_e = sb.pop_front();
         check("gnt", gnt, mon_e.gnt);
         check("owner_id", owner_id, mon_e.id);
         check("busy", busy, mon_e.busy);
         check("timeout", timeout, mon_e.to);
         check("gnt onehot0", $onehot0(gnt), 1);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int order[$];
      int gaps[$];
      int gap, hi_cnt, to_cnt;
      bit seen;
      logic [N-1:0] g_log[14];
      logic         to_log[14];
      logic [N-1:0] r, lk, ls;

      model_reset();
      @(posedge clk);
      #1;
      check("reset gnt", gnt, 0);
      check("reset owner_id", owner_id, 0);
      check("reset busy", busy, 0);
      check("reset timeout", timeout, 0);
      reset = 1'b0;

      // Single requester: grant two edges after the request, release on drop.
      drive(4'b0001, '0, '0);
      check("s1 busy in turn", busy, 1);
      check("s1 gnt in turn", gnt, 0);
      drive(4'b0001, '0, '0);
      check("s1 gnt", gnt, 4'b0001);
      drive(4'b0000, '0, '0);
      check("s1 gnt released", gnt, 0);
      check("s1 busy idle", busy, 0);

      // All request with last on every grant: strict rotation, one dead cycle between owners.
      do_reset(0);
      gap = 0;
      seen = 0;
      repeat (12) begin
         drive(4'b1111, '0, 4'b1111);
         if (gnt != 0) begin
            order.push_back(idx_of(gnt));
            if (seen) gaps.push_back(gap);
            gap  = 0;
            seen = 1;
         end else begin
            gap++;
         end
      end
      check("s2 grant count", order.size() >= 5, 1);
      for (int i = 0; i < 5 && i < order.size(); i++) check("s2 order", order[i], exp_order[i]);
      for (int i = 0; i < gaps.size(); i++) check("s2 dead gap", gaps[i], TURNAROUND);

      // Contention without lock: owner 0 forced off after MAX_HOLD cycles.
      do_reset(0);
      hi_cnt = 0;
      to_cnt = 0;
      for (int i = 1; i <= 13; i++) begin
         drive(4'b0011, '0, '0);
         g_log[i]  = gnt;
         to_log[i] = timeout;
         if (gnt == 4'b0001) hi_cnt++;
         if (timeout) to_cnt++;
      end
      check("s3 gnt0 cycles", hi_cnt, 8);
      check("s3 gnt0 last cycle", g_log[9], 4'b0001);
      check("s3 dead cycle", g_log[10], 0);
      check("s3 timeout pulse", to_log[10], 1);
      check("s3 timeout count", to_cnt, 1);
      check("s3 next owner", g_log[11], 4'b0010);

      // Lock keeps the bus under contention; a lone requester never times out.
      do_reset(0);
      hi_cnt = 0;
      to_cnt = 0;
      repeat (25) begin
         drive(4'b0011, 4'b0001, '0);
         if (gnt == 4'b0001) hi_cnt++;
         if (timeout) to_cnt++;
      end
      check("s4 locked hold", hi_cnt, 24);
      check("s4 locked no timeout", to_cnt, 0);
      do_reset(0);
      hi_cnt = 0;
      to_cnt = 0;
      repeat (15) begin
         drive(4'b0001, '0, '0);
         if (gnt == 4'b0001) hi_cnt++;
         if (timeout) to_cnt++;
      end
      check("s4 lone hold", hi_cnt, 14);
      check("s4 lone no timeout", to_cnt, 0);

      // Request dropped during turnaround: abort with no grant, pointer untouched.
      do_reset(0);
      drive(4'b0100, '0, '0);
      check("s5 pending owner", owner_id, 2);
      check("s5 busy in turn", busy, 1);
      drive(4'b0000, '0, '0);
      check("s5 abort busy", busy, 0);
      check("s5 abort gnt", gnt, 0);
      drive(4'b0000, '0, '0);
      drive(4'b0110, '0, '0);
      check("s5 pick after abort", owner_id, 1);
      drive(4'b0110, '0, '0);
      check("s5 gnt after abort", gnt, 4'b0010);

      // Asynchronous reset in the middle of a grant.
      do_reset(0);
      repeat (3) drive(4'b0010, '0, '0);
      check("s6 gnt before reset", gnt, 4'b0010);
      do_reset(1);
      check("s6 busy after reset", busy, 0);
      drive(4'b1001, '0, '0);
      drive(4'b1001, '0, '0);
      check("s6 first grant after reset", gnt, 4'b0001);

      // Random traffic with persistent requests, occasional locks and frequent last pulses.
      do_reset(0);
      r  = '0;
      lk = '0;
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         if ($urandom_range(0, 19) == 0) lk = N'($urandom_range(0, 15));
         for (int b = 0; b < N; b++) ls[b] = ($urandom_range(0, 3) == 0);
         drive(r, lk, ls);
      end

      @(negedge clk);
      #1;
      check("scoreboard drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
